// File: rtl/stopwatch_up.sv
// rtl/stopwatch_up.sv - MM:SS up-counting stopwatch with run/lap/pause control
// The displayed digits track the live count except while a lap hold is active.
module stopwatch_up (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       zero,
  input  logic       lap,
  output logic [3:0] sec_u,
  output logic [3:0] sec_t,
  output logic [3:0] min_u,
  output logic [3:0] min_t,
  output logic       running,
  output logic       frozen,
  output logic       wrap
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] RUN_LAP = 2'd2;
  localparam logic [1:0] PAUSE   = 2'd3;

  logic [1:0] state, state_nx;
  logic [3:0] su, st, mu, mt;
  logic [3:0] su_nx, st_nx, mu_nx, mt_nx;
  logic       cmd_start, cmd_stop, do_zero, inc, at_max, hold;

  // start and stop together cancel each other
  assign cmd_start = start & ~stop;
  assign cmd_stop  = stop & ~start;

  always_comb begin
    state_nx = state;
    do_zero  = 1'b0;
    case (state)
      IDLE:    if (cmd_start) state_nx = RUN;
      RUN: begin
        if (cmd_stop)  state_nx = PAUSE;
        else if (lap)  state_nx = RUN_LAP;
      end
      RUN_LAP: begin
        if (cmd_stop)  state_nx = PAUSE;
        else if (lap)  state_nx = RUN;
      end
      PAUSE: begin
        if (cmd_start) state_nx = RUN;
        else if (zero) begin
          state_nx = IDLE;
          do_zero  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign inc    = tick & ((state == RUN) | (state == RUN_LAP));
  assign at_max = (su == 4'd9) && (st == 4'd5) && (mu == 4'd9) && (mt == 4'd5);
  assign hold   = (state == RUN_LAP) && (state_nx == RUN_LAP);

  always_comb begin
    su_nx = su;
    st_nx = st;
    mu_nx = mu;
    mt_nx = mt;
    if (do_zero) begin
      su_nx = 4'd0;
      st_nx = 4'd0;
      mu_nx = 4'd0;
      mt_nx = 4'd0;
    end else if (inc) begin
      // >= comparisons keep every digit inside its range even from a bad value
      if (su >= 4'd9) begin
        su_nx = 4'd0;
        if (st >= 4'd5) begin
          st_nx = 4'd0;
          if (mu >= 4'd9) begin
            mu_nx = 4'd0;
            mt_nx = (mt >= 4'd5) ? 4'd0 : mt + 4'd1;
          end else begin
            mu_nx = mu + 4'd1;
          end
        end else begin
          st_nx = st + 4'd1;
        end
      end else begin
        su_nx = su + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      su    <= 4'd0;
      st    <= 4'd0;
      mu    <= 4'd0;
      mt    <= 4'd0;
      sec_u <= 4'd0;
      sec_t <= 4'd0;
      min_u <= 4'd0;
      min_t <= 4'd0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      su    <= su_nx;
      st    <= st_nx;
      mu    <= mu_nx;
      mt    <= mt_nx;
      if (!hold) begin
        sec_u <= su_nx;
        sec_t <= st_nx;
        min_u <= mu_nx;
        min_t <= mt_nx;
      end
      wrap  <= inc & at_max;
    end
  end

  assign running = (state == RUN) || (state == RUN_LAP);
  assign frozen  = (state == RUN_LAP);

endmodule

// File: tb/tb_stopwatch_up.sv
// tb/tb_stopwatch_up.sv - directed scoreboard bench for stopwatch_up
module tb_stopwatch_up;

  logic       clk = 1'b0;
  logic       clear, tick, start, stop, zero, lap;
  logic [3:0] sec_u, sec_t, min_u, min_t;
  logic       running, frozen, wrap;

  typedef struct {
    string       tag;
    logic [18:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  stopwatch_up dut (
    .clk(clk), .clear(clear), .tick(tick), .start(start), .stop(stop),
    .zero(zero), .lap(lap), .sec_u(sec_u), .sec_t(sec_t), .min_u(min_u),
    .min_t(min_t), .running(running), .frozen(frozen), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // {running, frozen, wrap, MM:SS as packed BCD}
  task automatic expect_out(input string tag, input logic r, input logic f,
                            input logic w, input logic [15:0] mmss);
    exp_t e;
    e.tag = tag;
    e.val = {r, f, w, mmss};
    exp_q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [18:0] obs;
    e   = exp_q.pop_front();
    obs = {running, frozen, wrap, min_t, min_u, sec_t, sec_u};
    vectors++;
    assert (obs === e.val) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic step(input logic t, input logic sa, input logic so,
                      input logic z, input logic l);
    tick = t; start = sa; stop = so; zero = z; lap = l;
    @(posedge clk);
    #1;
    tick = 0; start = 0; stop = 0; zero = 0; lap = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask

  task automatic pulse_clear();
    #2 clear = 1;
    #1;
    expect_out("clear_async", 0, 0, 0, 16'h0000);
    check();
    #2 clear = 0;
  endtask

  initial begin
    clear = 1; tick = 0; start = 0; stop = 0; zero = 0; lap = 0;
    #2;
    expect_out("reset", 0, 0, 0, 16'h0000); check();
    @(negedge clk) clear = 0;

    step(0, 0, 0, 0, 0);
    expect_out("idle_after_reset", 0, 0, 0, 16'h0000); check();
    step(1, 0, 0, 0, 0);
    expect_out("idle_tick_ignored", 0, 0, 0, 16'h0000); check();

    step(0, 1, 0, 0, 0);
    expect_out("start", 1, 0, 0, 16'h0000); check();
    ticks(10);
    expect_out("ten_ticks", 1, 0, 0, 16'h0010); check();

    ticks(3588);
    expect_out("preset_5958", 1, 0, 0, 16'h5958); check();
    step(1, 0, 0, 0, 0);
    expect_out("at_5959", 1, 0, 0, 16'h5959); check();
    step(1, 0, 0, 0, 0);
    expect_out("wrap_edge", 1, 0, 1, 16'h0000); check();
    step(0, 0, 0, 0, 0);
    expect_out("wrap_one_cycle", 1, 0, 0, 16'h0000); check();

    ticks(5);
    expect_out("at_0005", 1, 0, 0, 16'h0005); check();
    step(0, 0, 0, 0, 1);
    expect_out("lap_enter", 1, 1, 0, 16'h0005); check();
    ticks(3);
    expect_out("lap_hold", 1, 1, 0, 16'h0005); check();
    step(0, 0, 0, 0, 1);
    expect_out("lap_release", 1, 0, 0, 16'h0008); check();

    pulse_clear();
    step(0, 1, 0, 0, 0);
    ticks(7);
    expect_out("at_0007", 1, 0, 0, 16'h0007); check();
    step(1, 0, 1, 0, 0);
    expect_out("stop_with_tick", 0, 0, 0, 16'h0008); check();
    ticks(3);
    expect_out("pause_ticks", 0, 0, 0, 16'h0008); check();
    step(0, 0, 0, 1, 0);
    expect_out("zero_to_idle", 0, 0, 0, 16'h0000); check();

    step(1, 1, 0, 0, 0);
    expect_out("start_tick_no_count", 1, 0, 0, 16'h0000); check();
    step(0, 1, 1, 0, 0);
    expect_out("start_stop_cancel", 1, 0, 0, 16'h0000); check();
    step(1, 0, 0, 1, 0);
    expect_out("zero_ignored_run", 1, 0, 0, 16'h0001); check();
    step(0, 0, 1, 0, 0);
    expect_out("stop_to_pause", 0, 0, 0, 16'h0001); check();
    step(0, 1, 0, 1, 0);
    expect_out("start_beats_zero", 1, 0, 0, 16'h0001); check();
    step(0, 0, 1, 0, 1);
    expect_out("stop_beats_lap", 0, 0, 0, 16'h0001); check();

    pulse_clear();
    step(0, 1, 0, 0, 0);
    ticks(754);
    expect_out("at_1234", 1, 0, 0, 16'h1234); check();
    step(0, 0, 0, 0, 1);
    ticks(2);
    expect_out("lap_at_1234", 1, 1, 0, 16'h1234); check();
    pulse_clear();
    step(0, 0, 0, 0, 0);
    expect_out("after_clear_idle", 0, 0, 0, 16'h0000); check();
    step(0, 1, 0, 0, 0);
    expect_out("restart", 1, 0, 0, 16'h0000); check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
